seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Multiplexed, parametrised N-digit 7-segment display driver; successor to the single-digit combinational BCD decoder.
- Adds hex glyphs, a time-multiplexed digit scan, a tear-free shadow/display register pair, leading-zero blanking, per-digit decimal points, an anti-ghost blanking window and a selectable output polarity.
- Sits between the UART receive datapath (or any status source) and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- SCAN_DIV, 50000: clock cycles per digit slot; must be >= 2.
- BLANK_CYC, 16: cycles at the start of each slot during which no digit is enabled; must be < SCAN_DIV.
- HEX_EN, 1: 1 = codes 10..15 render A,b,C,d,E,F; 0 = codes 10..15 render all segments off.
- SEG_ACT_LOW, 0: 1 = seg_out and dp_out are active-low.
- DIG_ACT_LOW, 0: 1 = dig_sel is active-low.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- load  in  1  single-cycle strobe; captures data_in and dp_in into the shadow register
- data_in  in  4*NUM_DIGITS  nibble k is digit k; digit 0 is rightmost/least significant
- dp_in  in  NUM_DIGITS  decimal point request per digit
- blank_lz  in  1  1 = suppress leading zeros
- enable  in  1  0 = display dark, scan frozen
- seg_out  out  7  {g,f,e,d,c,b,a}, bit0 = a
- dp_out  out  1  decimal point segment
- dig_sel  out  NUM_DIGITS  one-hot digit enable
- frame_tick  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset state:
  - prescaler cnt = 0, digit index idx = 0, shadow = 0, display = 0.
  - seg_out and dp_out at their "off" level (0, or all-1 if SEG_ACT_LOW).
  - dig_sel all inactive; frame_tick = 0.
  - Reset asserted mid-scan takes effect on the next edge and aborts the slot. Pending shadow contents are lost.
- Prescaler (enable = 1):
  - cnt increments each cycle.
  - When cnt == SCAN_DIV-1: cnt <= 0 and idx <= idx+1.
  - idx wraps from NUM_DIGITS-1 to 0.
- Frame wrap:
  - Occurs when cnt == SCAN_DIV-1 and idx == NUM_DIGITS-1.
  - On that edge: display <= shadow, and frame_tick is registered high for exactly one cycle.
- enable = 0:
  - cnt, idx and display hold; shadow still loads.
  - Outputs go to the off/inactive level on the next edge.
  - Scan resumes from the held cnt/idx when enable returns to 1.
- load:
  - Shadow captures {data_in, dp_in} on any edge where load = 1, independent of enable.
  - Load coincident with a frame wrap: display takes the old shadow, shadow takes the new data. The new value becomes visible on the following frame.
  - Displayed digits never change within a frame (tear-free).
- Output registering:
  - All outputs are registered from the current (cnt, idx, display). Pins lag internal state by exactly 1 cycle.
  - dig_sel is one-hot at bit idx only when cnt >= BLANK_CYC and enable = 1; otherwise it is all inactive.
  - seg_out and dp_out are forced to off whenever dig_sel is inactive.
- Glyph map (active-high form):
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111
  - A = 1110111, b = 1111100, C = 0111001, d = 1011110, E = 1111001, F = 1110001
- Leading-zero blanking (blank_lz = 1):
  - Digit k is blanked (segments off, digit still strobed) if nibbles k..NUM_DIGITS-1 of display are all zero and k != 0.
  - Digit 0 is never blanked; an all-zero value shows a single "0".
  - dp_out is not affected by blanking.
- Polarity: SEG_ACT_LOW / DIG_ACT_LOW invert the pins only. Internal logic is unchanged.
- No combinational path from any input to any output.

Test Plan:
- Common bench parameters: NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, HEX_EN=1, active-high polarity.
- Reset:
  - Stimulus: hold rst_n = 0 for 3 cycles, then release with enable = 1.
  - Response: seg_out = 0, dig_sel = 0000 and frame_tick = 0 during reset. First dig_sel = 0001 appears on cycle 2 after release, lasts 3 cycles, then 0000 for 1 cycle.
- Scan order and frame tick:
  - Stimulus: load data_in = 16'h12AF, then let the scan run.
  - Response: after the next frame wrap, digits 0..3 show 1110001 (F), 1110111 (A), 1011011 (2), 0000110 (1). frame_tick pulses every 16 cycles.
- Tear-free update:
  - Stimulus: pulse load with 16'h0000 mid-frame.
  - Response: the remaining digits of the current frame still show 12AF; the new value appears only after the next frame_tick.
  - Stimulus: load coincident with a wrap.
  - Response: the new value is deferred by one further frame.
- Leading-zero blanking:
  - Stimulus: blank_lz = 1, data_in = 16'h0050, dp_in = 4'b1000.
  - Response: digits 3 and 2 have seg_out = 0, and digit 3 has dp_out = 1. Digit 1 shows 5; digit 0 shows 0.
  - Stimulus: data_in = 16'h0000.
  - Response: only digit 0 is lit, showing 0111111.
- HEX_EN = 0:
  - Stimulus: HEX_EN = 0 with data_in nibble = 4'hB.
  - Response: that digit's seg_out = 0000000.
- Enable and reset mid-scan:
  - Stimulus: deassert enable for 10 cycles.
  - Response: outputs go dark within 1 cycle; scan resumes at the held idx/cnt.
  - Stimulus: assert rst_n = 0 while idx = 2.
  - Response: idx returns to 0 and shadow to 0000.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment driver: shadow/display pair, hex glyphs, LZ blanking, scan.
// Latency: pins are registered and lag internal (cnt, idx, display) state by one cycle.
// Backpressure: none; load is a fire-and-forget strobe, the shadow always accepts it.
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   load         : strobe, captures data_in/dp_in into the shadow register
//   data_in      : 4*NUM_DIGITS nibbles, digit 0 is rightmost
//   dp_in        : decimal point request per digit
//   blank_lz     : suppress leading zeros
//   enable       : 0 = dark and scan frozen
//   seg_out      : {g,f,e,d,c,b,a}
//   dp_out       : decimal point segment
//   dig_sel      : one-hot digit enable
//   frame_tick   : one-cycle pulse at each frame wrap
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_CYC   = 16,
  parameter int HEX_EN      = 1,
  parameter int SEG_ACT_LOW = 0,
  parameter int DIG_ACT_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_dat_q, shadow_dat_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*NUM_DIGITS-1:0] disp_dat_q, disp_dat_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    tick_q, tick_d;

  logic                    slot_end;
  logic                    frame_wrap;
  logic                    lit;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    upper_zero;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0: g = 7'b0111111;
      4'h1: g = 7'b0000110;
      4'h2: g = 7'b1011011;
      4'h3: g = 7'b1001111;
      4'h4: g = 7'b1100110;
      4'h5: g = 7'b1101101;
      4'h6: g = 7'b1111101;
      4'h7: g = 7'b0000111;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1101111;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b1111100;
      4'hC: g = 7'b0111001;
      4'hD: g = 7'b1011110;
      4'hE: g = 7'b1111001;
      default: g = 7'b1110001;
    endcase
    if (HEX_EN == 0 && code > 4'd9) g = 7'b0000000;
    return g;
  endfunction

  // Leading-zero mask: digit k is blanked when it and every digit above it
  // are zero. Digit 0 is always shown so an all-zero value reads "0".
  always_comb begin
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (disp_dat_q[4*k +: 4] == 4'h0);
      lz_mask[k] = upper_zero && (k != 0);
    end
  end

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_nib = disp_dat_q[4*k +: 4];
        cur_dp  = disp_dp_q[k];
      end
    end
  end

  always_comb begin
    slot_end   = (cnt_q == CNT_LAST);
    frame_wrap = enable && slot_end && (idx_q == IDX_LAST);
    lit        = enable && (cnt_q >= CNT_BLANK);

    cnt_d        = cnt_q;
    idx_d        = idx_q;
    disp_dat_d   = disp_dat_q;
    disp_dp_d    = disp_dp_q;
    shadow_dat_d = shadow_dat_q;
    shadow_dp_d  = shadow_dp_q;

    if (enable) begin
      if (slot_end) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Display copies the shadow as it was before this edge, so a load on the
    // wrap edge itself lands one frame later and a frame never tears.
    if (frame_wrap) begin
      disp_dat_d = shadow_dat_q;
      disp_dp_d  = shadow_dp_q;
    end
    if (load) begin
      shadow_dat_d = data_in;
      shadow_dp_d  = dp_in;
    end

    dig_d  = '0;
    seg_d  = 7'b0000000;
    dp_d   = 1'b0;
    tick_d = frame_wrap;
    if (lit) begin
      for (int k = 0; k < NUM_DIGITS; k++) dig_d[k] = (idx_q == IW'(k));
      dp_d = cur_dp;
      if (!(blank_lz && lz_mask[idx_q])) seg_d = glyph(cur_nib);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_dat_q <= '0;
      shadow_dp_q  <= '0;
      disp_dat_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      dig_q        <= '0;
      tick_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_dat_q <= shadow_dat_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_dat_q   <= disp_dat_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_q        <= dig_d;
      tick_q       <= tick_d;
    end
  end

  // Polarity is applied after the flops so internal state stays active-high.
  assign seg_out    = (SEG_ACT_LOW != 0) ? ~seg_q : seg_q;
  assign dp_out     = (SEG_ACT_LOW != 0) ? ~dp_q  : dp_q;
  assign dig_sel    = (DIG_ACT_LOW != 0) ? ~dig_q : dig_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with a 4-digit, 4-cycle-slot configuration.
// Latency: expected pin words are queued per frame and compared one per cycle.
// Backpressure: none; stimulus is driven on falling edges, pins sampled there too.
module tb_seg7_scan_driver;

  localparam logic [6:0] G0 = 7'b0111111, G1 = 7'b0000110, G2 = 7'b1011011;
  localparam logic [6:0] G3 = 7'b1001111, G4 = 7'b1100110, G5 = 7'b1101101;
  localparam logic [6:0] G6 = 7'b1111101, G7 = 7'b0000111, G8 = 7'b1111111;
  localparam logic [6:0] G9 = 7'b1101111, GB = 7'b1111100;
  localparam logic [6:0] GC = 7'b0111001, GD = 7'b1011110, GE = 7'b1111001;
  localparam logic [6:0] GF = 7'b1110001, GA = 7'b1110111, GX = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst_n, load, blank_lz, enable;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg_out, nh_seg;
  logic        dp_out, nh_dp, frame_tick, nh_tick;
  logic [3:0]  dig_sel, nh_dig;

  int total = 0;
  int bad   = 0;

  // {main{tick,dp,dig,seg}, nohex{tick,dp,dig,seg}}
  logic [25:0] sb[$];

  typedef struct {
    logic [15:0] dat;
    logic [3:0]  dp;
    logic        blz;
    logic [27:0] es;
    logic [3:0]  edp;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .HEX_EN(1),
                     .SEG_ACT_LOW(0), .DIG_ACT_LOW(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .enable(enable), .seg_out(seg_out), .dp_out(dp_out),
    .dig_sel(dig_sel), .frame_tick(frame_tick));

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .HEX_EN(0),
                     .SEG_ACT_LOW(0), .DIG_ACT_LOW(0)) u_nohex (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .enable(enable), .seg_out(nh_seg), .dp_out(nh_dp),
    .dig_sel(nh_dig), .frame_tick(nh_tick));

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got{tick,dp,dig,seg}=%b required=%b", name, $time, got, exp);
    end
  endtask

  task automatic check_dark(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_main"}, {frame_tick, dp_out, dig_sel, seg_out}, 13'd0);
      check({tag, "_nohex"}, {nh_tick, nh_dp, nh_dig, nh_seg}, 13'd0);
    end
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] p, input logic b);
    data_in  = d;
    dp_in    = p;
    blank_lz = b;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      if (frame_tick) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s frame_tick got=none_in_64_cycles required=pulse", tag);
    end
  endtask

  // Starts on the falling edge right after a frame wrap (or reset release).
  // es/edp: expected segments/dp per digit; dat: displayed value, used for the
  // HEX_EN=0 instance. ld_at/off_at are sample indices for mid-frame actions.
  task automatic run_frame(input string tag, input logic [27:0] es, input logic [3:0] edp,
                           input logic [15:0] dat, input int nsamp, input int ld_at,
                           input logic [15:0] ld_dat, input int off_at);
    logic [12:0] m, n;
    logic [6:0]  sg;
    logic [3:0]  nib;
    logic [25:0] e;
    int slot, pos, s;
    for (int j = 0; j < nsamp; j++) begin
      slot = j / 4;
      pos  = j % 4;
      if (pos == 0) begin
        m = 13'd0;
        n = 13'd0;
      end else begin
        sg  = es[slot*7 +: 7];
        nib = dat[slot*4 +: 4];
        m = {1'(j == 15), edp[slot], 4'(1 << slot), sg};
        n = {1'(j == 15), edp[slot], 4'(1 << slot), (nib > 4'd9) ? GX : sg};
      end
      sb.push_back({m, n});
      if (j == off_at) for (int d = 0; d < 10; d++) sb.push_back(26'd0);
    end
    s = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      check({tag, "_main"}, {frame_tick, dp_out, dig_sel, seg_out}, e[25:13]);
      check({tag, "_nohex"}, {nh_tick, nh_dp, nh_dig, nh_seg}, e[12:0]);
      load = (s == ld_at);
      if (s == ld_at) begin
        data_in = ld_dat;
        dp_in   = 4'b0000;
      end
      if (s == off_at) enable = 1'b0;
      if (off_at >= 0 && s == off_at + 10) enable = 1'b1;
      s++;
    end
  endtask

  initial begin
    vecs[0] = '{16'h0050, 4'b1000, 1'b1, {GX, GX, G5, G0}, 4'b1000};
    vecs[1] = '{16'h0000, 4'b0000, 1'b1, {GX, GX, GX, G0}, 4'b0000};
    vecs[2] = '{16'h0000, 4'b0000, 1'b0, {G0, G0, G0, G0}, 4'b0000};
    vecs[3] = '{16'h789B, 4'b0101, 1'b0, {G7, G8, G9, GB}, 4'b0101};
    vecs[4] = '{16'h6CDE, 4'b0000, 1'b1, {G6, GC, GD, GE}, 4'b0000};
    vecs[5] = '{16'h0304, 4'b0010, 1'b1, {GX, G3, G0, G4}, 4'b0010};
    vecs[6] = '{16'h0001, 4'b1111, 1'b1, {GX, GX, GX, G1}, 4'b1111};
    vecs[7] = '{16'h12AF, 4'b0000, 1'b0, {G1, G2, GA, GF}, 4'b0000};

    rst_n    = 1'b0;
    load     = 1'b0;
    enable   = 1'b1;
    blank_lz = 1'b0;
    data_in  = 16'h0000;
    dp_in    = 4'b0000;

    // Reset: dark pins, then first digit strobe two cycles after release.
    check_dark("reset", 3);
    rst_n = 1'b1;
    run_frame("post_reset", {G0, G0, G0, G0}, 4'b0000, 16'h0000, 16, -1, 16'h0, -1);

    // Glyphs, decimal points and leading-zero blanking, one frame each.
    for (int i = 0; i < 8; i++) begin
      pulse_load(vecs[i].dat, vecs[i].dp, vecs[i].blz);
      wait_tick($sformatf("vec%0d_wait", i));
      run_frame($sformatf("vec%0d", i), vecs[i].es, vecs[i].edp, vecs[i].dat, 16, -1, 16'h0, -1);
    end

    // Tear-free: 12AF on display, load 0000 mid-frame; frame completes as 12AF.
    run_frame("tear_mid", {G1, G2, GA, GF}, 4'b0000, 16'h12AF, 16, 5, 16'h0000, -1);
    // Now shows 0000; load 12AF on the wrap edge itself.
    run_frame("tear_wrap_ld", {G0, G0, G0, G0}, 4'b0000, 16'h0000, 16, 14, 16'h12AF, -1);
    run_frame("tear_deferred", {G0, G0, G0, G0}, 4'b0000, 16'h0000, 16, -1, 16'h0, -1);
    // 12AF finally visible; drop enable for 10 cycles mid-frame.
    run_frame("enable_gap", {G1, G2, GA, GF}, 4'b0000, 16'h12AF, 16, -1, 16'h0, 6);

    // Load 789B early in the frame, then reset while idx = 2: shadow is lost.
    run_frame("pre_reset", {G1, G2, GA, GF}, 4'b0000, 16'h12AF, 10, 3, 16'h789B, -1);
    rst_n = 1'b0;
    check_dark("mid_reset", 3);
    rst_n = 1'b1;
    run_frame("mid_reset_f0", {G0, G0, G0, G0}, 4'b0000, 16'h0000, 16, -1, 16'h0, -1);
    run_frame("mid_reset_f1", {G0, G0, G0, G0}, 4'b0000, 16'h0000, 16, -1, 16'h0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
